// File: rtl/sva_latency_pipe.sv
// DEPTH-stage valid/data pipeline with a global stall and a registered in-flight count.
// Embedded assertions check latency, stall stability, the occupancy bound and data zeroing.
module sva_latency_pipe #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 3,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       stall,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] inflight
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] stageValid_q, stageValid_d;
    logic [WIDTH-1:0] stageData_q [DEPTH];
    logic [WIDTH-1:0] stageData_d [DEPTH];
    logic [CW-1:0]    inflight_q, inflight_d;

    // Count is taken from the next-state valids so it tracks the stages in the same cycle.
    always_comb begin
        stageValid_d = stageValid_q;
        stageData_d  = stageData_q;
        if (!stall) begin
            stageValid_d[0] = in_valid;
            stageData_d[0]  = (ZERO_INVALID && !in_valid) ? '0 : in_data;
            for (int i = 1; i < DEPTH; i++) begin
                stageValid_d[i] = stageValid_q[i-1];
                stageData_d[i]  = stageData_q[i-1];
            end
        end
        inflight_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inflight_d = inflight_d + CW'(stageValid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stageValid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stageData_q[i] <= '0;
            end
            inflight_q <= '0;
        end else begin
            stageValid_q <= stageValid_d;
            stageData_q  <= stageData_d;
            inflight_q   <= inflight_d;
        end
    end

    assign out_valid = stageValid_q[DEPTH-1];
    assign out_data  = stageData_q[DEPTH-1];
    assign inflight  = inflight_q;

`ifndef SYNTHESIS
`ifdef FAIL
    localparam int LAT = DEPTH - 1;
`else
    localparam int LAT = DEPTH;
`endif
    localparam int HL = (LAT < 1) ? 1 : LAT;

    // chain_q[k]: an item was accepted k edges ago and every edge since then was unstalled.
    logic [HL:1]      chain_q;
    logic [WIDTH-1:0] dataHist_q [1:HL];
    logic             latDue;
    logic [WIDTH-1:0] latData;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q[1] <= in_valid && !stall;
            for (int k = 2; k <= HL; k++) begin
                chain_q[k] <= chain_q[k-1] && !stall;
            end
        end
        dataHist_q[1] <= in_data;
        for (int k = 2; k <= HL; k++) begin
            dataHist_q[k] <= dataHist_q[k-1];
        end
    end

    generate
        if (LAT == 0) begin : gLatNow
            assign latDue  = in_valid && !stall;
            assign latData = in_data;
        end else begin : gLatPast
            assign latDue  = chain_q[LAT];
            assign latData = dataHist_q[LAT];
        end
    endgenerate

    a_latency: assert property (@(posedge clk) disable iff (reset)
        latDue |-> (out_valid && out_data == latData))
        else $error("a_latency: out_valid=%0b out_data=%h", $sampled(out_valid), $sampled(out_data));

    a_stall_hold: assert property (@(posedge clk) disable iff (reset)
        stall |=> ($stable(out_valid) && $stable(out_data) && $stable(inflight)))
        else $error("a_stall_hold: out_valid=%0b out_data=%h inflight=%0d",
                    $sampled(out_valid), $sampled(out_data), $sampled(inflight));

    a_bound: assert property (@(posedge clk) disable iff (reset)
        inflight <= CW'(DEPTH))
        else $error("a_bound: inflight=%0d", $sampled(inflight));

    generate
        if (ZERO_INVALID) begin : gZero
            a_zero: assert property (@(posedge clk) disable iff (reset)
                !out_valid |-> out_data == '0)
                else $error("a_zero: out_data=%h", $sampled(out_data));
        end
    endgenerate
`endif

endmodule

// File: tb/tb_sva_latency_pipe.sv
// Directed bench: DEPTH=3 pipe with and without data zeroing, plus a DEPTH=1 pipe on the same inputs.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
module tb_sva_latency_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       stall;

    logic       outValid, outValidNz, outValid1;
    logic [7:0] outData, outDataNz, outData1;
    logic [1:0] inflight, inflightNz;
    logic [0:0] inflight1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sva_latency_pipe #(.WIDTH(8), .DEPTH(3), .ZERO_INVALID(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .stall(stall),
        .out_valid(outValid), .out_data(outData), .inflight(inflight)
    );

    sva_latency_pipe #(.WIDTH(8), .DEPTH(3), .ZERO_INVALID(1'b0)) dutNz (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .stall(stall),
        .out_valid(outValidNz), .out_data(outDataNz), .inflight(inflightNz)
    );

    sva_latency_pipe #(.WIDTH(8), .DEPTH(1), .ZERO_INVALID(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .stall(stall),
        .out_valid(outValid1), .out_data(outData1), .inflight(inflight1)
    );

    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d, input logic s);
        reset    = r;
        in_valid = v;
        in_data  = d;
        stall    = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkMain(input string tag, input logic v, input logic [7:0] d, input logic [1:0] f);
        checkOutput({tag, ".out_valid"}, 32'(outValid), 32'(v));
        checkOutput({tag, ".out_data"},  32'(outData),  32'(d));
        checkOutput({tag, ".inflight"},  32'(inflight), 32'(f));
    endtask

    logic [7:0] burstData [1:7];
    logic       burstValid [1:7];
    logic [1:0] burstFlight [1:7];

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b1, 8'hEE, 1'b0);
        tick();
        tick();
        checkMain("reset", 1'b0, 8'h00, 2'd0);
        checkOutput("reset.nz_out_data", 32'(outDataNz), 32'h0);
        checkOutput("reset.d1_out_valid", 32'(outValid1), 32'h0);

        // Single item A5, no stall
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkMain("single.c1", 1'b0, 8'h00, 2'd1);
        checkOutput("single.d1_out_valid", 32'(outValid1), 32'h1);
        checkOutput("single.d1_out_data", 32'(outData1), 32'hA5);
        checkOutput("single.d1_inflight", 32'(inflight1), 32'h1);
        tick();
        checkMain("single.c2", 1'b0, 8'h00, 2'd1);
        checkOutput("single.d1_c2_out_valid", 32'(outValid1), 32'h0);
        tick();
        checkMain("single.c3", 1'b1, 8'hA5, 2'd1);
        tick();
        checkMain("single.c4", 1'b0, 8'h00, 2'd0);

        // Burst 01..04 on consecutive edges
        burstValid  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        burstData   = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        burstFlight = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4) applyStimulus(1'b0, 1'b1, 8'(c), 1'b0);
            else        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            tick();
            checkMain($sformatf("burst.c%0d", c), burstValid[c], burstData[c], burstFlight[c]);
        end

        // 3C then two stalled edges offering 77, then a stall while 3C sits at the output
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0);
        tick();
        checkMain("stall.c1", 1'b0, 8'h00, 2'd1);
        applyStimulus(1'b0, 1'b1, 8'h77, 1'b1);
        tick();
        checkMain("stall.c2", 1'b0, 8'h00, 2'd1);
        tick();
        checkMain("stall.c3", 1'b0, 8'h00, 2'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        checkMain("stall.c4", 1'b0, 8'h00, 2'd1);
        tick();
        checkMain("stall.c5", 1'b1, 8'h3C, 2'd1);
        applyStimulus(1'b0, 1'b1, 8'h77, 1'b1);
        tick();
        checkMain("stall.c6_hold", 1'b1, 8'h3C, 2'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 7; c <= 9; c++) begin
            tick();
            checkMain($sformatf("stall.c%0d", c), 1'b0, 8'h00, 2'd0);
        end

        // Reset mid-flight discards 10 and 11; reset also overrides in_valid
        applyStimulus(1'b0, 1'b1, 8'h10, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 8'h11, 1'b0);
        tick();
        checkMain("rst.c2", 1'b0, 8'h00, 2'd2);
        applyStimulus(1'b1, 1'b1, 8'h12, 1'b0);
        tick();
        checkMain("rst.c3", 1'b0, 8'h00, 2'd0);
        checkOutput("rst.d1_out_valid", 32'(outValid1), 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 4; c <= 8; c++) begin
            tick();
            checkMain($sformatf("rst.c%0d", c), 1'b0, 8'h00, 2'd0);
        end

        // Invalid FF: zeroed in one instance, stale in the other
        applyStimulus(1'b0, 1'b0, 8'hFF, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            checkMain($sformatf("zero.c%0d", c), 1'b0, 8'h00, 2'd0);
        end
        checkOutput("nozero.out_valid", 32'(outValidNz), 32'h0);
        checkOutput("nozero.out_data", 32'(outDataNz), 32'hFF);
        checkOutput("nozero.inflight", 32'(inflightNz), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
